// File: rtl/regfile_mp_pkg.sv
// Shared defaults and clear/ready state encoding for the multi-port register file.
package regfile_mp_pkg;

    localparam int unsigned RF_DATA_WIDTH = 64;
    localparam int unsigned RF_ADDR_BITS  = 5;
    localparam int unsigned RF_NUM_READ   = 2;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, set wins; bit 0 never busy.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int unsigned ADDR_BITS = RF_ADDR_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      set_en,
    input  logic [ADDR_BITS-1:0]      set_addr,
    input  logic                      clr_en,
    input  logic [ADDR_BITS-1:0]      clr_addr,
    output logic [(2**ADDR_BITS)-1:0] busy
);

    localparam int unsigned DEPTH = 2**ADDR_BITS;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int j = 1; j < DEPTH; j++) begin
                if (set_en && set_addr == ADDR_BITS'(j)) begin
                    busy[j] <= 1'b1;
                end else if (clr_en && clr_addr == ADDR_BITS'(j)) begin
                    busy[j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardware clear, write-to-read bypass and busy scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_BITS  = RF_ADDR_BITS,
    parameter int unsigned NUM_READ   = RF_NUM_READ
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic                           ready,
    input  logic [NUM_READ*ADDR_BITS-1:0]  rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_BITS-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           iss_en,
    input  logic [ADDR_BITS-1:0]           iss_addr
);

    localparam int unsigned DEPTH = 2**ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    rf_state_e              state_q, state_d;
    logic [ADDR_BITS-1:0]   clr_ptr_q, clr_ptr_d;
    logic                   clr_we;
    logic                   rf_ready;
    logic                   wr_fire;
    logic                   iss_fire;
    logic [DATA_WIDTH-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]       busy;

    assign rf_ready = (state_q == RF_READY);
    assign wr_fire  = rf_ready && wr_en && (wr_addr != '0);
    assign iss_fire = rf_ready && iss_en && (iss_addr != '0);

    // Clear sequence walks r1..r(DEPTH-1) once, then holds in READY.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                clr_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + ADDR_BITS'(1);
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = RF_READY;
                end
            end
            RF_READY: begin
                state_d = RF_READY;
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RF_CLEAR;
            clr_ptr_q <= ADDR_BITS'(1);
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready     <= (state_d == RF_READY);
        end
    end

    // Storage has no reset; the clear walk defines every readable entry.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs[clr_ptr_q] <= '0;
        end else if (wr_fire) begin
            regs[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_BITS (ADDR_BITS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (iss_fire),
        .set_addr (iss_addr),
        .clr_en   (wr_fire),
        .clr_addr (wr_addr),
        .busy     (busy)
    );

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_BITS-1:0] addr;
        logic                 hit;

        assign addr = rd_addr[i*ADDR_BITS +: ADDR_BITS];
        assign hit  = wr_fire && (wr_addr == addr);

        // Outputs forced quiet while clearing; busy is already zero then.
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
            !rf_ready      ? '0      :
            hit            ? wr_data :
            (addr == '0)   ? '0      : regs[addr];
        assign rd_busy[i] = rf_ready && busy[addr] && !hit;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear timing, read/write, bypass, scoreboard, r0, reset mid-clear.
module tb_regfile_mp;

    localparam int unsigned DW = 64;
    localparam int unsigned AB = 5;
    localparam int unsigned NR = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              ready;
    logic [NR*AB-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wr_en;
    logic [AB-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              iss_en;
    logic [AB-1:0]     iss_addr;

    int n_pass  = 0;
    int n_total = 0;

    regfile_mp #(
        .DATA_WIDTH (DW),
        .ADDR_BITS  (AB),
        .NUM_READ   (NR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AB-1:0] a);
        rd_addr[p*AB +: AB] = a;
    endtask

    function automatic logic [DW-1:0] port_data(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    initial begin
        int cyc;
        int nonzero;
        int busy_seen;

        reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        step();
        step();
        check("ready_in_reset", 64'(ready), 64'd0);

        // Reset-and-clear: writes and issues during CLEAR must be ignored.
        reset = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h99;
        iss_en = 1'b1; iss_addr = 5'd6;
        set_rd(0, 5'd5); set_rd(1, 5'd6);
        #1;
        check("clear_rd_data_gated", port_data(0), 64'd0);
        cyc = 0; busy_seen = 0;
        while (!ready && cyc < 40) begin
            step();
            cyc++;
            if (rd_busy != '0) busy_seen++;
        end
        wr_en = 1'b0; iss_en = 1'b0;
        check("ready_latency", 64'(cyc), 64'd31);
        check("busy_during_clear", 64'(busy_seen), 64'd0);
        #1;
        nonzero = 0; busy_seen = 0;
        for (int a = 0; a < 32; a++) begin
            set_rd(0, AB'(a)); set_rd(1, AB'(31 - a));
            #1;
            if (port_data(0) != '0 || port_data(1) != '0) nonzero++;
            if (rd_busy != '0) busy_seen++;
        end
        check("all_zero_after_clear", 64'(nonzero), 64'd0);
        check("none_busy_after_clear", 64'(busy_seen), 64'd0);

        // Basic write then read on both ports.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hDEADBEEF_00000001;
        step();
        wr_en = 1'b0;
        set_rd(0, 5'd7); set_rd(1, 5'd7);
        #1;
        check("r7_port0", port_data(0), 64'hDEADBEEF_00000001);
        check("r7_port1", port_data(1), 64'hDEADBEEF_00000001);

        // Bypass: same-cycle write is visible on the read port.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h11;
        step();
        wr_en = 1'b0; set_rd(0, 5'd3); set_rd(1, 5'd7);
        #1;
        check("r3_old", port_data(0), 64'h11);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h55;
        #1;
        check("r3_bypass", port_data(0), 64'h55);
        check("r7_no_bypass", port_data(1), 64'hDEADBEEF_00000001);
        step();
        wr_en = 1'b0;
        #1;
        check("r3_stored", port_data(0), 64'h55);

        // Scoreboard set, set/clear collision, then clear.
        set_rd(0, 5'd9); set_rd(1, 5'd9);
        iss_en = 1'b1; iss_addr = 5'd9;
        #1;
        check("r9_busy_before_edge", 64'(rd_busy[0]), 64'd0);
        step();
        iss_en = 1'b0;
        #1;
        check("r9_busy_p0", 64'(rd_busy[0]), 64'd1);
        check("r9_busy_p1", 64'(rd_busy[1]), 64'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hA0;
        iss_en = 1'b1; iss_addr = 5'd9;
        #1;
        check("r9_bypass_hides_busy", 64'(rd_busy[0]), 64'd0);
        check("r9_bypass_data", port_data(0), 64'hA0);
        step();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        check("r9_collision_data", port_data(0), 64'hA0);
        check("r9_collision_busy", 64'(rd_busy[0]), 64'd1);
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        iss_en = 1'b0;
        #1;
        check("r9_reissue_busy", 64'(rd_busy[1]), 64'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hB0;
        step();
        wr_en = 1'b0;
        #1;
        check("r9_cleared_busy", 64'(rd_busy[0]), 64'd0);
        check("r9_final_data", port_data(1), 64'hB0);

        // r0 immunity.
        set_rd(0, 5'd0); set_rd(1, 5'd0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'hFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        check("r0_no_bypass", port_data(0), 64'd0);
        step();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        check("r0_data", port_data(1), 64'd0);
        check("r0_busy", 64'(rd_busy), 64'd0);

        // Reset mid-clear after r20 holds data.
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'h1234;
        step();
        wr_en = 1'b0; set_rd(0, 5'd20); set_rd(1, 5'd21);
        #1;
        check("r20_written", port_data(0), 64'h1234);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 9; k++) step();
        check("ready_low_mid_clear", 64'(ready), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'h77;
        iss_en = 1'b1; iss_addr = 5'd21;
        cyc = 0;
        while (!ready && cyc < 40) begin
            step();
            cyc++;
        end
        wr_en = 1'b0; iss_en = 1'b0;
        check("restart_ready_latency", 64'(cyc), 64'd31);
        #1;
        check("r20_cleared", port_data(0), 64'd0);
        check("r21_not_busy", 64'(rd_busy[1]), 64'd0);
        check("r20_not_busy", 64'(rd_busy[0]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the multicycle datapath; next generation of the single-write, two-read regfile.
- Adds:
  - synchronous reset with a hardware clear sequence
  - write-to-read bypass
  - per-register busy scoreboard, so control can stall on in-flight multicycle results
- Register 0 is hardwired zero.
- Sits between decode (read/issue) and writeback (write).

Parameters:
- DATA_WIDTH, 64, width of each register and data bus.
- ADDR_BITS, 5, register address width; depth = 2**ADDR_BITS.
- NUM_READ, 2, number of independent combinational read ports (1..4).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high once the clear sequence has completed.
- rd_addr  in  NUM_READ*ADDR_BITS  flattened read addresses; port i at bits [i*ADDR_BITS +: ADDR_BITS].
- rd_data  out  NUM_READ*DATA_WIDTH  flattened read data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- rd_busy  out  NUM_READ  port i register has an outstanding producer.
- wr_en  in  1  writeback enable.
- wr_addr  in  ADDR_BITS  writeback destination.
- wr_data  in  DATA_WIDTH  writeback value.
- iss_en  in  1  issue: mark destination busy.
- iss_addr  in  ADDR_BITS  issued destination register.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on rising clk.

Reset and clear FSM (states CLEAR, READY):
- reset=1 for one or more cycles: state<=CLEAR, clr_ptr<=1, busy vector<=0, ready<=0.
- CLEAR: each cycle writes 0 to regs[clr_ptr] and increments clr_ptr.
  - When clr_ptr == 2**ADDR_BITS-1 is written, state<=READY.
  - ready=1 from the following cycle; with the default parameters, on the 31st rising edge after reset deasserts.
- CLEAR: wr_en and iss_en are ignored. All rd_data=0 and all rd_busy=0.
- reset asserted mid-CLEAR or in READY restarts the sequence from clr_ptr=1.
- ready is a registered output, 0 during reset and CLEAR.

Register 0:
- Always reads 0 and is never busy.
- Writes and issues to address 0 are ignored.

Write (READY only):
- wr_en && wr_addr!=0 → regs[wr_addr]<=wr_data on the rising edge.
- Also clears busy[wr_addr], unless an issue to the same address happens in the same cycle (see below).

Issue (READY only):
- iss_en && iss_addr!=0 → busy[iss_addr]<=1.
- Simultaneous issue and write to the same address: data is written AND busy stays 1. The new producer wins.
- Issue to an already-busy register keeps it busy; no error is raised.

Read (combinational, per port i):
- Bypass hit = ready && wr_en && wr_addr!=0 && wr_addr==rd_addr_i.
- rd_data_i = bypass hit ? wr_data : (rd_addr_i==0 ? 0 : regs[rd_addr_i]).
- rd_busy_i = busy[rd_addr_i] && !bypass hit.
- Any number of ports may read the same address in one cycle; all return identical values.

Other rules:
- A write to a non-busy register is legal and updates data normally.
- No X propagation: the entire array is defined after the clear sequence.

Decomposition:
- Shared parameter include (params.v) holds:
  - DATA_WIDTH and ADDR_BITS defaults
  - FSM state encodings RF_CLEAR=1'b0, RF_READY=1'b1
- One sub-module, regfile_scoreboard:
  - 2**ADDR_BITS busy bits, with set (issue) / clear (write) / reset.
  - Set takes priority over clear; bit 0 is tied to 0.
  - Instantiated once.
- Read ports are generated with a generate loop over NUM_READ.

Test Plan:
- Reset-and-clear: pulse reset 1 cycle, then count cycles.
  - ready rises exactly 31 cycles later (ADDR_BITS=5).
  - Every address then reads 0; rd_busy=0 throughout.
- Basic write/read: write 0xDEADBEEF_00000001 to r7, next cycle read r7 on port 0 and port 1.
  - Both return 0xDEADBEEF_00000001.
- Bypass: in one cycle, wr_en to r3 with value 0x55 while rd_addr port0=3 (old value 0x11).
  - rd_data port0=0x55 in the same cycle; after the edge, the stored value is 0x55.
- Scoreboard and collision: iss r9; next cycle rd_busy(r9)=1. Then write r9=0xA0 with simultaneous iss r9.
  - Data reads 0xA0 and rd_busy stays 1.
  - A later write r9 alone clears rd_busy to 0.
- r0 immunity: write r0=0xFF and iss r0.
  - r0 reads 0 and rd_busy=0.
- Reset mid-clear: assert reset while clr_ptr=10 after prior writes to r20.
  - Clear restarts; ready rises 31 cycles after deassert.
  - r20 reads 0; writes issued during CLEAR have no effect.
